// File: rtl/keypad_entry.sv
// keypad_entry: debounces a one-hot decimal keypad and shifts accepted digits
// into an M:SS BCD entry (mins, sec_tens, sec_ones).
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad,
    input  logic       clearn,
    input  logic       load_en,
    output logic       digit_valid,
    output logic       key_reject,
    output logic [3:0] digit,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] digit_count,
    output logic       nonzero
);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next, cnt_inc;
    logic [9:0] code_reg, code_next;

    logic       key_seen, key_multi, key_valid, key_zero, same_key;
    logic [3:0] key_bin;
    logic       press_done, room, accept, reject;

    // Single pass over the keypad: detects one-hot and encodes the digit.
    always_comb begin
        key_seen  = 1'b0;
        key_multi = 1'b0;
        key_bin   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                key_multi = key_multi | key_seen;
                key_seen  = 1'b1;
                key_bin   = 4'(i);
            end
        end
    end

    assign key_valid = key_seen && !key_multi;
    assign key_zero  = (keypad == 10'd0);
    assign same_key  = (keypad == code_reg);
    assign cnt_inc   = cnt_reg + 4'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            code_reg  <= 10'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            code_reg  <= code_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        case (state_reg)
            S_IDLE: begin
                if (key_valid) begin
                    code_next = keypad;
                    if (press_done) begin
                        state_next = S_HELD;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = S_PRESS;
                        cnt_next   = 4'd1;
                    end
                end
            end
            S_PRESS: begin
                if (!same_key) begin
                    state_next = S_IDLE;
                    cnt_next   = 4'd0;
                end else if (press_done) begin
                    state_next = S_HELD;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_HELD: begin
                if (key_zero) begin
                    if (DEB == 4'd1) begin
                        state_next = S_IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = S_RELEASE;
                        cnt_next   = 4'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (!key_zero) begin
                    state_next = S_HELD;
                    cnt_next   = 4'd0;
                end else if (cnt_inc == DEB) begin
                    state_next = S_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
        // Clear parks the FSM in HELD so a key still down must be released first.
        if (!clearn) begin
            state_next = S_HELD;
            cnt_next   = 4'd0;
        end
    end

    always_comb begin
        press_done = 1'b0;
        if (state_reg == S_IDLE) begin
            press_done = key_valid && (DEB == 4'd1);
        end else if (state_reg == S_PRESS) begin
            press_done = same_key && (cnt_inc == DEB);
        end
        // A third digit is only legal when the current units digit can become tens.
        room   = load_en && (digit_count != 2'd3) && (sec_ones <= 4'd5);
        accept = clearn && press_done && room;
        reject = clearn && press_done && !room;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digit_valid <= 1'b0;
            key_reject  <= 1'b0;
            digit       <= 4'd0;
            mins        <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 2'd0;
        end else begin
            digit_valid <= accept;
            key_reject  <= reject;
            if (!clearn) begin
                digit       <= 4'd0;
                mins        <= 4'd0;
                sec_tens    <= 4'd0;
                sec_ones    <= 4'd0;
                digit_count <= 2'd0;
            end else if (accept) begin
                mins        <= sec_tens;
                sec_tens    <= sec_ones;
                sec_ones    <= key_bin;
                digit       <= key_bin;
                digit_count <= digit_count + 2'd1;
            end
        end
    end

    assign nonzero = (mins != 4'd0) || (sec_tens != 4'd0) || (sec_ones != 4'd0);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random keypad traffic,
// checked against a run-length reference model of the debounce rules.
module tb_keypad_entry;
    localparam int D = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] keypad = 10'd0;
    logic       clearn = 1'b1;
    logic       load_en = 1'b1;
    logic       digit_valid, key_reject, nonzero;
    logic [3:0] digit, mins, sec_tens, sec_ones;
    logic [1:0] digit_count;

    keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .resetn(resetn), .keypad(keypad), .clearn(clearn),
        .load_en(load_en), .digit_valid(digit_valid), .key_reject(key_reject),
        .digit(digit), .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .digit_count(digit_count), .nonzero(nonzero)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a press is D identical one-hot samples while armed;
    // re-arming needs D consecutive all-zero samples.
    logic [3:0] m_mins, m_tens, m_ones, m_digit;
    logic [1:0] m_count;
    logic       m_dv, m_kr, armed;
    int         run_len, zero_len;
    logic [9:0] run_key;

    function automatic logic [3:0] key_index(input logic [9:0] k);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) if (k[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [20:0] obs_vec();
        return {digit_valid, key_reject, digit, mins, sec_tens, sec_ones, digit_count, nonzero};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {m_dv, m_kr, m_digit, m_mins, m_tens, m_ones, m_count,
                (m_mins != 4'd0) || (m_tens != 4'd0) || (m_ones != 4'd0)};
    endfunction

    task automatic model_reset();
        m_mins = 0; m_tens = 0; m_ones = 0; m_digit = 0; m_count = 0;
        m_dv = 0; m_kr = 0; armed = 1; run_len = 0; zero_len = 0; run_key = 0;
    endtask

    task automatic model_edge(input logic [9:0] kp, input logic cl, input logic le);
        m_dv = 0;
        m_kr = 0;
        if (!cl) begin
            m_mins = 0; m_tens = 0; m_ones = 0; m_digit = 0; m_count = 0;
            armed = 0; run_len = 0; zero_len = 0;
        end else if (armed) begin
            if (run_len > 0 && kp == run_key) run_len++;
            else if (run_len > 0) run_len = 0;
            else if ($countones(kp) == 1) begin run_len = 1; run_key = kp; end
            if (run_len == D) begin
                armed = 0; run_len = 0; zero_len = 0;
                if (le && m_count < 3 && m_ones <= 5) begin
                    m_mins = m_tens; m_tens = m_ones; m_ones = key_index(run_key);
                    m_digit = m_ones; m_count = m_count + 2'd1; m_dv = 1;
                end else begin
                    m_kr = 1;
                end
            end
        end else begin
            if (kp == 10'd0) zero_len++;
            else zero_len = 0;
            if (zero_len == D) begin armed = 1; run_len = 0; end
        end
    endtask

    task automatic step(input logic [9:0] kp, input logic cl, input logic le);
        @(negedge clock);
        keypad = kp; clearn = cl; load_en = le;
        @(posedge clock);
        if (!resetn) model_reset();
        else model_edge(kp, cl, le);
        #1;
    endtask

    task automatic press_key(input logic [9:0] kp, input int hold, input int gap, input logic le,
                             output int dv_n, output int kr_n, output logic [3:0] last_d);
        dv_n = 0; kr_n = 0; last_d = 4'hf;
        for (int c = 0; c < hold + gap; c++) begin
            step((c < hold) ? kp : 10'd0, 1'b1, le);
            if (digit_valid) begin dv_n++; last_d = digit; end
            if (key_reject) kr_n++;
        end
    endtask

    task automatic clear_entry();
        step(10'd0, 1'b0, 1'b1);
        for (int c = 0; c < D + 1; c++) step(10'd0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        tests_run++;
        if (obs_vec() !== 21'd0) begin
            tests_failed++; $display("FAIL reset_state got %h expected 0", obs_vec());
        end
        step(10'd2, 1'b1, 1'b1);
        step(10'd2, 1'b1, 1'b1);
        tests_run++;
        if (obs_vec() !== 21'd0) begin
            tests_failed++; $display("FAIL reset_hold got %h expected 0", obs_vec());
        end
        @(negedge clock);
        resetn = 1'b1;
        $display("[TB] reset: outputs %h", obs_vec());
    endtask

    task automatic test_three_digits();
        int dv, kr, tot;
        logic [3:0] d;
        logic [3:0] keys [3];
        keys = '{4'd3, 4'd5, 4'd9};
        tot = 0;
        clear_entry();
        for (int k = 0; k < 3; k++) begin
            press_key(10'd1 << keys[k], 11, 11, 1'b1, dv, kr, d);
            tot += dv;
            tests_run++;
            if (dv !== 1 || kr !== 0 || d !== keys[k]) begin
                tests_failed++;
                $display("FAIL digit_%0d got dv=%0d kr=%0d digit=%0d expected dv=1 kr=0 digit=%0d",
                         k, dv, kr, d, keys[k]);
            end
            $display("[TB] three_digits: key %0d -> dv=%0d digit=%0d", keys[k], dv, d);
        end
        tests_run++;
        if ({mins, sec_tens, sec_ones, digit_count, nonzero} !== {4'd3, 4'd5, 4'd9, 2'd3, 1'b1} || tot != 3) begin
            tests_failed++;
            $display("FAIL entry_359 got %0d:%0d%0d count=%0d nz=%0d pulses=%0d expected 3:59 count=3 nz=1 pulses=3",
                     mins, sec_tens, sec_ones, digit_count, nonzero, tot);
        end
    endtask

    task automatic test_reject_units();
        int dv, kr;
        logic [3:0] d;
        clear_entry();
        press_key(10'd1 << 2, 11, 11, 1'b1, dv, kr, d);
        press_key(10'd1 << 7, 11, 11, 1'b1, dv, kr, d);
        tests_run++;
        if ({mins, sec_tens, sec_ones, digit_count} !== {4'd0, 4'd2, 4'd7, 2'd2}) begin
            tests_failed++;
            $display("FAIL entry_027 got %0d:%0d%0d count=%0d expected 0:27 count=2", mins, sec_tens, sec_ones, digit_count);
        end
        press_key(10'd1 << 5, 11, 11, 1'b1, dv, kr, d);
        $display("[TB] reject_units: key 5 -> dv=%0d kr=%0d", dv, kr);
        tests_run++;
        if (dv !== 0 || kr !== 1 || {mins, sec_tens, sec_ones, digit_count} !== {4'd0, 4'd2, 4'd7, 2'd2}) begin
            tests_failed++;
            $display("FAIL reject_5 got dv=%0d kr=%0d %0d:%0d%0d count=%0d expected dv=0 kr=1 0:27 count=2",
                     dv, kr, mins, sec_tens, sec_ones, digit_count);
        end
    endtask

    task automatic test_glitch();
        int dv, kr, dv2, kr2, d1;
        logic [3:0] d;
        logic [9:0] pat [6];
        pat = '{10'd16, 10'd16, 10'd0, 10'd16, 10'd16, 10'd0};
        clear_entry();
        dv = 0; kr = 0;
        for (int c = 0; c < 6; c++) begin
            step(pat[c], 1'b1, 1'b1);
            dv += int'(digit_valid); kr += int'(key_reject);
        end
        press_key(10'd16, 5, 5, 1'b1, dv2, kr2, d);
        d1 = int'(d);
        $display("[TB] glitch: bounce pulses=%0d, steady press dv=%0d ones=%0d", dv + kr, dv2, sec_ones);
        tests_run++;
        if (dv + kr !== 0) begin
            tests_failed++; $display("FAIL glitch_pulse got %0d pulses expected 0", dv + kr);
        end
        tests_run++;
        if (dv2 !== 1 || kr2 !== 0 || d1 !== 4 || sec_ones !== 4'd4) begin
            tests_failed++;
            $display("FAIL glitch_accept got dv=%0d kr=%0d ones=%0d expected dv=1 kr=0 ones=4", dv2, kr2, sec_ones);
        end
    endtask

    task automatic test_full_and_load();
        int dv, kr;
        logic [3:0] d;
        clear_entry();
        press_key(10'd1 << 3, 6, 6, 1'b1, dv, kr, d);
        press_key(10'd1 << 5, 6, 6, 1'b1, dv, kr, d);
        press_key(10'd1 << 9, 6, 6, 1'b1, dv, kr, d);
        press_key(10'd1 << 1, 6, 6, 1'b1, dv, kr, d);
        tests_run++;
        if (dv !== 0 || kr !== 1 || {mins, sec_tens, sec_ones, digit_count} !== {4'd3, 4'd5, 4'd9, 2'd3}) begin
            tests_failed++;
            $display("FAIL full_reject got dv=%0d kr=%0d %0d:%0d%0d expected dv=0 kr=1 3:59", dv, kr, mins, sec_tens, sec_ones);
        end
        clear_entry();
        press_key(10'd1 << 1, 6, 6, 1'b0, dv, kr, d);
        $display("[TB] load_disabled: dv=%0d kr=%0d entry %0d:%0d%0d", dv, kr, mins, sec_tens, sec_ones);
        tests_run++;
        if (dv !== 0 || kr !== 1 || {mins, sec_tens, sec_ones, digit_count, nonzero} !== 15'd0) begin
            tests_failed++;
            $display("FAIL load_reject got dv=%0d kr=%0d %0d:%0d%0d nz=%0d expected dv=0 kr=1 0:00 nz=0",
                     dv, kr, mins, sec_tens, sec_ones, nonzero);
        end
    endtask

    task automatic test_multibit();
        int dv, kr;
        logic [3:0] d;
        clear_entry();
        press_key(10'b0000000110, 10, 4, 1'b1, dv, kr, d);
        $display("[TB] multibit: dv=%0d kr=%0d", dv, kr);
        tests_run++;
        if (dv !== 0 || kr !== 0 || digit_count !== 2'd0) begin
            tests_failed++; $display("FAIL multibit got dv=%0d kr=%0d count=%0d expected 0 0 0", dv, kr, digit_count);
        end
    endtask

    task automatic test_clear_and_reset();
        int dv, kr, n;
        logic [3:0] d;
        clear_entry();
        press_key(10'd1 << 1, 5, 5, 1'b1, dv, kr, d);
        press_key(10'd1 << 2, 5, 5, 1'b1, dv, kr, d);
        step(10'd1 << 6, 1'b1, 1'b1);
        step(10'd1 << 6, 1'b0, 1'b1);
        press_key(10'd1 << 6, 8, 0, 1'b1, dv, kr, d);
        tests_run++;
        if (dv !== 0 || kr !== 0 || {digit, mins, sec_tens, sec_ones, digit_count} !== 18'd0) begin
            tests_failed++;
            $display("FAIL clear_held got dv=%0d kr=%0d vec=%h expected no pulse and all zero",
                     dv, kr, {digit, mins, sec_tens, sec_ones, digit_count});
        end
        press_key(10'd0, 5, 0, 1'b1, dv, kr, d);
        press_key(10'd1 << 6, 5, 5, 1'b1, dv, kr, d);
        $display("[TB] clear: re-press 6 -> dv=%0d ones=%0d count=%0d", dv, sec_ones, digit_count);
        tests_run++;
        if (dv !== 1 || sec_ones !== 4'd6 || digit_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL clear_repress got dv=%0d ones=%0d count=%0d expected 1 6 1", dv, sec_ones, digit_count);
        end
        press_key(10'd1 << 7, 2, 0, 1'b1, dv, kr, d);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (obs_vec() !== 21'd0) begin
            tests_failed++; $display("FAIL async_reset got %h expected 0", obs_vec());
        end
        step(10'd0, 1'b1, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        press_key(10'd0, 8, 0, 1'b1, dv, kr, d);
        tests_run++;
        if (dv + kr !== 0 || obs_vec() !== 21'd0) begin
            tests_failed++; $display("FAIL reset_discard got pulses=%0d vec=%h expected 0", dv + kr, obs_vec());
        end
        // Key held across reset counts as a fresh press afterwards.
        press_key(10'd1 << 8, 1, 0, 1'b1, dv, kr, d);
        resetn = 1'b0;
        model_reset();
        step(10'd1 << 8, 1'b1, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        press_key(10'd1 << 8, 5, 5, 1'b1, n, kr, d);
        $display("[TB] reset_held: dv=%0d ones=%0d", n, sec_ones);
        tests_run++;
        if (n !== 1 || kr !== 0 || sec_ones !== 4'd8 || digit_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL reset_held got dv=%0d kr=%0d ones=%0d count=%0d expected 1 0 8 1", n, kr, sec_ones, digit_count);
        end
    endtask

    task automatic test_random();
        int len, kind, errs, pulses;
        logic [9:0] kp;
        logic cl, le, prev_pulse;
        errs = 0; pulses = 0; prev_pulse = 0;
        clear_entry();
        for (int s = 0; s < 150; s++) begin
            len  = $urandom_range(1, 8);
            kind = $urandom_range(0, 19);
            le   = ($urandom_range(0, 9) != 0);
            if (kind < 8) kp = 10'd0;
            else if (kind < 16) kp = 10'd1 << $urandom_range(0, 9);
            else if (kind < 18) kp = 10'($urandom_range(1, 1023));
            else kp = 10'd0;
            for (int c = 0; c < len; c++) begin
                cl = !(kind >= 18 && c == 0);
                step(kp, cl, le);
                pulses += int'(digit_valid | key_reject);
                tests_run++;
                if (obs_vec() !== exp_vec() || (digit_valid && key_reject) ||
                    (prev_pulse && (digit_valid || key_reject))) begin
                    tests_failed++; errs++;
                    $display("FAIL random step %0d.%0d kp=%b got %h expected %h", s, c, kp, obs_vec(), exp_vec());
                end
                prev_pulse = digit_valid | key_reject;
            end
        end
        $display("[TB] random: %0d pulses seen, %0d mismatching steps", pulses, errs);
    endtask

    initial begin
        test_reset();
        test_three_digits();
        test_reject_units();
        test_glitch();
        test_full_and_load();
        test_multibit();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
